// File: rtl/voter_ballot_collector_if.sv
// voter_ballot_collector_if: vote strobes in, ballot/verdict out under a valid/ack handshake
interface voter_ballot_collector_if;
    logic       start;
    logic [3:0] vote_valid;
    logic [3:0] vote_yes;
    logic [3:0] ballot;
    logic [3:0] voted;
    logic [3:1] result;
    logic       ballot_valid;
    logic       ballot_ack;
    logic       timed_out;
    logic       busy;
    modport master (
        output start, vote_valid, vote_yes, ballot_ack,
        input  ballot, voted, result, ballot_valid, timed_out, busy
    );
    modport slave (
        input  start, vote_valid, vote_yes, ballot_ack,
        output ballot, voted, result, ballot_valid, timed_out, busy
    );
endinterface

// File: rtl/voter_ballot_collector.sv
// voter_ballot_collector: gathers one vote per voter per session, closes on all-voted or timeout
module voter_ballot_collector #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 10
) (
    input logic                     clk,
    input logic                     rst,
    voter_ballot_collector_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_ballot, r_voted;
    logic [3:1]       r_result;
    logic             r_timed_out;
    logic [3:0]       w_accept, w_ballot, w_voted;
    logic [2:0]       w_n;
    logic [3:1]       w_result;
    logic             w_done, w_tmo;
    // only first vote per voter is taken; later strobes on a voted bit are masked
    assign w_accept = bus.vote_valid & ~r_voted;
    assign w_voted  = r_voted | bus.vote_valid;
    assign w_ballot = (r_ballot & ~w_accept) | (bus.vote_yes & w_accept);
    assign w_done   = &w_voted;
    assign w_tmo    = r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign w_n      = 3'(w_ballot[0]) + 3'(w_ballot[1]) + 3'(w_ballot[2]) + 3'(w_ballot[3]);
    assign w_result = (w_n <= 3'd1) ? 3'b100 : (w_n == 3'd2) ? 3'b010 : 3'b001;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ballot    <= '0;
            r_voted     <= '0;
            r_result    <= '0;
            r_timed_out <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (bus.start) begin
                r_state     <= S_COLLECT;
                r_cnt       <= '0;
                r_ballot    <= '0;
                r_voted     <= '0;
                r_timed_out <= 1'b0;
            end
        end else if (r_state == S_COLLECT) begin
            r_ballot <= w_ballot;
            r_voted  <= w_voted;
            r_cnt    <= r_cnt + CNT_W'(1);
            // completion takes priority over a coincident timeout
            if (w_done || w_tmo) begin
                r_state     <= S_PRESENT;
                r_result    <= w_result;
                r_timed_out <= ~w_done;
            end
        end else if (bus.ballot_ack) begin
            r_state <= S_IDLE;
        end
    end
    assign bus.ballot       = r_ballot;
    assign bus.voted        = r_voted;
    assign bus.result       = r_result;
    assign bus.timed_out    = r_timed_out;
    assign bus.ballot_valid = r_state == S_PRESENT;
    assign bus.busy         = r_state != S_IDLE;
endmodule

// File: tb/tb_voter_ballot_collector.sv
// tb_voter_ballot_collector: directed sessions with a scoreboard popped on each ballot_valid rise
module tb_voter_ballot_collector;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    logic [11:0] exp_q[$];
    logic pv = 1'b0;
    voter_ballot_collector_if bus();
    voter_ballot_collector #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(string n, logic [15:0] a, logic [15:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic set_votes(logic [3:0] v, logic [3:0] y);
        bus.vote_valid = v;
        bus.vote_yes = y;
    endtask
    task automatic open_session();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask
    task automatic ack_ballot();
        bus.ballot_ack = 1'b1;
        tick();
        bus.ballot_ack = 1'b0;
        chk("ack_idle", {14'b0, bus.ballot_valid, bus.busy}, 16'h0);
    endtask
    // {ballot, voted, result, timed_out} compared once per presented ballot
    always @(negedge clk) begin
        if (bus.ballot_valid && !pv) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ballot actual=%h expected=none", {bus.ballot, bus.voted, bus.result, bus.timed_out});
            end else
                chk("ballot", {4'b0, bus.ballot, bus.voted, bus.result, bus.timed_out}, {4'b0, exp_q.pop_front()});
        end
        pv = bus.ballot_valid;
    end
    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.ballot_ack = 1'b0;
        set_votes(4'b0, 4'b0);
        tick();
        tick();
        chk("reset", {bus.ballot, bus.voted, bus.result, bus.ballot_valid, bus.timed_out, bus.busy}, 16'h0);
        rst = 1'b0;
        tick();
        open_session();
        chk("busy_collect", {15'b0, bus.busy}, 16'h1);
        set_votes(4'b0001, 4'b0001);
        tick();
        set_votes(4'b0010, 4'b0010);
        tick();
        set_votes(4'b1000, 4'b1000);
        tick();
        chk("valid_before_last", {15'b0, bus.ballot_valid}, 16'h0);
        exp_q.push_back({4'b1011, 4'b1111, 3'b001, 1'b0});
        set_votes(4'b0100, 4'b0000);
        tick();
        set_votes(4'b0, 4'b0);
        chk("valid_latency", {15'b0, bus.ballot_valid}, 16'h1);
        ack_ballot();
        open_session();
        exp_q.push_back({4'b0011, 4'b1111, 3'b010, 1'b0});
        set_votes(4'b1111, 4'b0011);
        tick();
        chk("valid_all_at_once", {15'b0, bus.ballot_valid}, 16'h1);
        set_votes(4'b1111, 4'b0000);
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold", {3'b0, bus.ballot, bus.voted, bus.result, bus.timed_out, bus.ballot_valid}, {3'b0, 4'b0011, 4'b1111, 3'b010, 1'b0, 1'b1});
        end
        bus.start = 1'b0;
        set_votes(4'b0, 4'b0);
        ack_ballot();
        chk("retain_idle", {5'b0, bus.ballot, bus.voted, bus.result}, {5'b0, 4'b0011, 4'b1111, 3'b010});
        bus.ballot_ack = 1'b1;
        open_session();
        bus.ballot_ack = 1'b1;
        set_votes(4'b0010, 4'b0010);
        tick();
        set_votes(4'b0, 4'b0);
        tick();
        tick();
        set_votes(4'b0010, 4'b0000);
        tick();
        exp_q.push_back({4'b0010, 4'b1111, 3'b100, 1'b0});
        set_votes(4'b1101, 4'b0000);
        tick();
        set_votes(4'b0, 4'b0);
        chk("valid_revote", {15'b0, bus.ballot_valid}, 16'h1);
        tick();
        chk("ack_held_idle", {14'b0, bus.ballot_valid, bus.busy}, 16'h0);
        tick();
        chk("ack_held_no_restart", {15'b0, bus.busy}, 16'h0);
        bus.ballot_ack = 1'b0;
        open_session();
        set_votes(4'b0001, 4'b0001);
        tick();
        set_votes(4'b0, 4'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_early_timeout", {15'b0, bus.ballot_valid}, 16'h0);
        end
        exp_q.push_back({4'b0001, 4'b0001, 3'b100, 1'b1});
        tick();
        chk("timeout_valid", {15'b0, bus.ballot_valid}, 16'h1);
        ack_ballot();
        open_session();
        set_votes(4'b0111, 4'b0110);
        tick();
        set_votes(4'b0, 4'b0);
        for (int i = 0; i < 6; i++) tick();
        chk("last_cycle_pending", {15'b0, bus.ballot_valid}, 16'h0);
        exp_q.push_back({4'b1110, 4'b1111, 3'b001, 1'b0});
        set_votes(4'b1000, 4'b1000);
        tick();
        set_votes(4'b0, 4'b0);
        chk("completion_beats_timeout", {14'b0, bus.ballot_valid, bus.timed_out}, 16'h2);
        ack_ballot();
        open_session();
        set_votes(4'b0011, 4'b0011);
        tick();
        set_votes(4'b0, 4'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {bus.ballot, bus.voted, bus.result, bus.ballot_valid, bus.timed_out, bus.busy}, 16'h0);
        rst = 1'b0;
        tick();
        open_session();
        chk("clean_session", {11'b0, bus.voted, bus.busy}, 16'h1);
        exp_q.push_back({4'b1111, 4'b1111, 3'b001, 1'b0});
        set_votes(4'b1111, 4'b1111);
        tick();
        set_votes(4'b0, 4'b0);
        ack_ballot();
        tick();
        tick();
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/voter_ballot_collector.md
Name: voter_ballot_collector

Overview:
- Front-end for the 4-voter majority logic: runs a voting session and gathers one vote per voter through per-voter valid strobes.
- Ends the session when all four voters have voted, or on timeout.
- Presents the assembled 4-bit ballot vector together with a registered one-hot verdict, held under a valid/ack handshake.
- Absent voters count as "no".

Parameters:
- TIMEOUT_CYCLES, 1000: COLLECT cycles allowed before the session is forced closed; must be >= 2.
- CNT_W, 10: session counter width; requires 2^CNT_W >= TIMEOUT_CYCLES.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  opens a session; sampled only in IDLE.
- vote_valid  input  4  per-voter vote strobe; bit i belongs to voter i.
- vote_yes  input  4  per-voter vote value, qualified by vote_valid[i]; 1 = yes.
- ballot  output  4  registered ballot vector, bit i = voter i's accepted vote.
- voted  output  4  registered flags, bit i = voter i has voted this session.
- result  output  3  one-hot verdict, indexed [3:1]: bit3 = reject (0-1 yes), bit2 = tie (2 yes), bit1 = pass (3-4 yes).
- ballot_valid  output  1  high in PRESENT; ballot and result are stable while high.
- ballot_ack  input  1  consumer accepts the ballot.
- timed_out  output  1  session was closed by timeout; valid while ballot_valid is high.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, any state): state IDLE, counter 0. Outputs ballot 0000, voted 0000, result 000, ballot_valid 0, timed_out 0, busy 0.
- States: IDLE, COLLECT, PRESENT. All outputs are registered.
- IDLE:
  - start=1 at an edge: clear ballot, voted, timed_out and counter; go to COLLECT.
  - vote_valid and ballot_ack are ignored.
- COLLECT:
  - Each edge, for every i with vote_valid[i]=1 and voted[i]=0: set voted[i]=1 and ballot[i]=vote_yes[i].
  - A vote_valid on an already-voted bit is ignored; the first vote is final.
  - Any number of voters may be accepted in the same cycle.
  - Counter increments by 1 per COLLECT cycle.
  - Completion: if the voted set after this edge's update is 1111, go to PRESENT on the same edge. result is computed from the updated ballot and registered on that edge; timed_out=0.
  - Timeout: if counter == TIMEOUT_CYCLES-1 and completion is not met, accept this edge's votes, go to PRESENT, set timed_out=1. Unvoted bits stay ballot=0.
  - If completion and timeout occur on the same edge, completion wins (timed_out=0).
  - start is ignored in COLLECT.
- Latency: ballot_valid rises at the same edge that accepts the last vote, i.e. it is visible in the following cycle. No additional pipeline stage.
- Verdict rule: n = popcount(ballot).
  - n <= 1: result = 100.
  - n == 2: result = 010.
  - n >= 3: result = 001.
  - Exactly one result bit is set from the first PRESENT onward.
- PRESENT:
  - ballot_valid=1; ballot, voted, result and timed_out are held constant.
  - ballot_ack=1 at an edge: go to IDLE; ballot_valid falls on that edge.
  - ballot, voted, result and timed_out retain their values in IDLE until the next start.
  - start and vote_valid are ignored in PRESENT.
  - ack held high continuously closes exactly one ballot; the next session still needs start.
- busy = (state != IDLE).
- Reset mid-session discards all votes immediately. No ballot_valid is produced for the aborted session.

Test Plan:
- Reset, start, then voters 0,1,3 vote yes on separate cycles and voter 2 votes no last → ballot 1011, voted 1111, result 001, timed_out 0, ballot_valid high the cycle after voter 2's vote.
- Start, all four vote_valid=1111 in one cycle with vote_yes=0011 → PRESENT next cycle, ballot 0011, result 010. Hold ack low 5 cycles → outputs stable. Pulse ack → ballot_valid 0, busy 0.
- Voter 1 votes yes, then voter 1 votes no 3 cycles later, then the others vote no → ballot 0010 (revote ignored), result 100.
- TIMEOUT_CYCLES=8: start, only voter 0 votes yes → ballot_valid after the 8th COLLECT cycle, ballot 0001, voted 0001, result 100, timed_out 1.
- TIMEOUT_CYCLES=8: three votes early, fourth vote (yes) arrives exactly on counter=7 → ballot includes it, voted 1111, timed_out 0.
- Assert rst mid-COLLECT after two votes → all outputs 0 immediately (async). A new start begins a clean session with voted 0000.
